// File: rtl/byte_serializer.sv
// Byte serializer: accepts a 32-bit word as four byte lanes under valid/ready and
// streams it out one byte per cycle, most-significant lane first, with a last flag.
module byte_serializer #(
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in1,
    input  logic [BYTE_W-1:0] in2,
    input  logic [BYTE_W-1:0] in3,
    input  logic [BYTE_W-1:0] in4,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int WORD_W = 4 * BYTE_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_hold;
    logic [1:0]          r_idx;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [BYTE_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_out_last;

    logic [WORD_W-1:0]   w_lanes;
    logic                w_accept;
    logic [1:0]          w_idx_inc;

    // Byte idx of a held word; idx 0 is the most-significant lane.
    function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = word[WORD_W-1   -: BYTE_W];
            2'd1:    b = word[3*BYTE_W-1 -: BYTE_W];
            2'd2:    b = word[2*BYTE_W-1 -: BYTE_W];
            default: b = word[BYTE_W-1   -: BYTE_W];
        endcase
        return b;
    endfunction

    assign w_lanes   = {in1, in2, in3, in4};
    assign w_idx_inc = r_idx + 2'd1;

    // Refill is allowed while the last byte leaves, so words stream without a bubble.
    assign in_ready  = (r_state == IDLE) ||
                       ((r_state == SEND) && (r_idx == 2'd3) && out_ready);
    assign w_accept  = in_valid && in_ready;

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign word_cnt  = r_word_cnt;

    // Control FSM with registered stream outputs and the completed-word counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_hold      <= {WORD_W{1'b0}};
            r_idx       <= 2'd0;
            r_word_cnt  <= {CNT_W{1'b0}};
            r_out_data  <= {BYTE_W{1'b0}};
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_hold      <= w_lanes;
                        r_idx       <= 2'd0;
                        r_state     <= SEND;
                        r_out_data  <= pick_byte(w_lanes, 2'd0);
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (r_idx != 2'd3) begin
                            r_idx      <= w_idx_inc;
                            r_out_data <= pick_byte(r_hold, w_idx_inc);
                            r_out_last <= (w_idx_inc == 2'd3);
                        end else begin
                            r_word_cnt <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            if (w_accept) begin
                                r_hold      <= w_lanes;
                                r_idx       <= 2'd0;
                                r_out_data  <= pick_byte(w_lanes, 2'd0);
                                r_out_valid <= 1'b1;
                                r_out_last  <= 1'b0;
                            end else begin
                                // idx stays at 3 so out_data keeps showing the held byte at idx.
                                r_state     <= IDLE;
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_idx       <= 2'd0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: scoreboard of {last, byte} entries
// pushed when a word is offered and popped when the DUT transfers a byte.
module tb_byte_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] in1, in2, in3, in4;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] word_cnt;

    int         n_checks;
    int         n_fail;
    logic [8:0] q[$];
    logic [7:0] exp_cnt;

    byte_serializer #(.BYTE_W(8), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .in4      (in4),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .word_cnt (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a word on the lanes and queue its four expected bytes.
    task automatic offer_word(input logic [31:0] w);
        in1 = w[31:24];
        in2 = w[23:16];
        in3 = w[15:8];
        in4 = w[7:0];
        q.push_back({1'b0, w[31:24]});
        q.push_back({1'b0, w[23:16]});
        q.push_back({1'b0, w[15:8]});
        q.push_back({1'b1, w[7:0]});
    endtask

    task automatic test_reset;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in1 = 8'h00; in2 = 8'h00; in3 = 8'h00; in4 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_cnt = 8'd0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_checks++; if (word_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single;
        logic [8:0] e;
        int budget;
        @(negedge clk);
        out_ready = 1'b1;
        offer_word(32'hAA55FF00);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_gap out_valid got %b want 1", out_valid); end
            if (out_valid && out_ready) begin
                e = q.pop_front();
                n_checks++;
                if ({out_last, out_data} !== e) begin n_fail++; $display("FAIL single_byte got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]); end
                if (e[8]) exp_cnt = exp_cnt + 8'd1;
            end
            budget--;
            @(negedge clk); #1;
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL single_timeout got %0d left want 0", q.size()); q.delete(); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle out_valid got %b want 0", out_valid); end
        n_checks++; if (word_cnt !== exp_cnt) begin n_fail++; $display("FAIL single_word_cnt got %0d want %0d", word_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [8:0] e;
        int budget;
        int npop;
        @(negedge clk);
        out_ready = 1'b1;
        offer_word(32'h11223344);
        in_valid = 1'b1;
        @(negedge clk);
        offer_word(32'hA1B2C3D4);
        #1;
        budget = 30;
        npop = 0;
        while (q.size() > 0 && budget > 0) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap out_valid got %b want 1", out_valid); end
            n_checks++; if (in_ready !== q[0][8]) begin n_fail++; $display("FAIL b2b_in_ready got %b want %b at byte %0d", in_ready, q[0][8], npop); end
            if (out_valid && out_ready) begin
                e = q.pop_front();
                npop++;
                n_checks++;
                if ({out_last, out_data} !== e) begin n_fail++; $display("FAIL b2b_byte got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]); end
                if (e[8]) exp_cnt = exp_cnt + 8'd1;
            end
            budget--;
            @(negedge clk);
            if (npop == 4) in_valid = 1'b0;
            #1;
        end
        in_valid = 1'b0;
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL b2b_timeout got %0d left want 0", q.size()); q.delete(); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle out_valid got %b want 0", out_valid); end
        n_checks++; if (word_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_word_cnt got %0d want %0d", word_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure;
        logic [8:0] e;
        int budget;
        @(negedge clk);
        out_ready = 1'b1;
        offer_word(32'h01020304);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        e = q.pop_front();
        n_checks++; if ({out_valid, out_last, out_data} !== {1'b1, e}) begin n_fail++; $display("FAIL bp_first got v=%b data=%h want v=1 data=%h", out_valid, out_data, e[7:0]); end
        @(negedge clk);
        out_ready = 1'b0;
        in1 = 8'hFF; in2 = 8'hFF; in3 = 8'hFF; in4 = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h02}) begin n_fail++; $display("FAIL bp_hold got v=%b l=%b data=%h want v=1 l=0 data=02", out_valid, out_last, out_data); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        #1;
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            if (out_valid && out_ready) begin
                e = q.pop_front();
                n_checks++;
                if ({out_last, out_data} !== e) begin n_fail++; $display("FAIL bp_byte got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]); end
                if (e[8]) exp_cnt = exp_cnt + 8'd1;
            end
            budget--;
            @(negedge clk); #1;
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL bp_timeout got %0d left want 0", q.size()); q.delete(); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle out_valid got %b want 0", out_valid); end
        n_checks++; if (word_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_word_cnt got %0d want %0d", word_cnt, exp_cnt); end
    endtask

    task automatic test_mid_reset;
        logic [8:0] e;
        int budget;
        @(negedge clk);
        out_ready = 1'b1;
        in1 = 8'h01; in2 = 8'h02; in3 = 8'h03; in4 = 8'h04;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_data !== 8'h01) begin n_fail++; $display("FAIL mr_byte0 got %h want 01", out_data); end
        @(negedge clk); #1;
        n_checks++; if (out_data !== 8'h02) begin n_fail++; $display("FAIL mr_byte1 got %h want 02", out_data); end
        @(negedge clk); #1;
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h03}) begin n_fail++; $display("FAIL mr_byte2 got v=%b data=%h want v=1 data=03", out_valid, out_data); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 8'd0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid got %b want 0", out_valid); end
        n_checks++; if (word_cnt !== 8'd0) begin n_fail++; $display("FAIL mr_word_cnt got %0d want 0", word_cnt); end
        @(negedge clk);
        offer_word(32'hDEADBEEF);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mr_gap out_valid got %b want 1", out_valid); end
            if (out_valid && out_ready) begin
                e = q.pop_front();
                n_checks++;
                if ({out_last, out_data} !== e) begin n_fail++; $display("FAIL mr_byte got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]); end
                if (e[8]) exp_cnt = exp_cnt + 8'd1;
            end
            budget--;
            @(negedge clk); #1;
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL mr_timeout got %0d left want 0", q.size()); q.delete(); end
        n_checks++; if (word_cnt !== exp_cnt) begin n_fail++; $display("FAIL mr_after_word_cnt got %0d want %0d", word_cnt, exp_cnt); end
    endtask

    task automatic test_wrap;
        logic [8:0] e;
        int budget;
        int sent;
        logic accepted;
        logic saw_wrap;
        @(negedge clk);
        out_ready = 1'b1;
        sent = 0;
        saw_wrap = 1'b0;
        offer_word($urandom);
        in_valid = 1'b1;
        #1;
        budget = 2000;
        while ((sent < 256 || q.size() > 0) && budget > 0) begin
            if (out_valid && out_ready) begin
                n_checks++; if (word_cnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_word_cnt got %0d want %0d", word_cnt, exp_cnt); end
                if (q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL wrap_extra got data=%h want no byte", out_data);
                end else begin
                    e = q.pop_front();
                    n_checks++;
                    if ({out_last, out_data} !== e) begin n_fail++; $display("FAIL wrap_byte got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]); end
                    if (e[8]) begin
                        exp_cnt = exp_cnt + 8'd1;
                        if (exp_cnt == 8'd0) saw_wrap = 1'b1;
                    end
                end
            end
            accepted = in_valid && in_ready;
            @(negedge clk);
            if (accepted) begin
                sent++;
                if (sent < 256) offer_word($urandom);
                else in_valid = 1'b0;
            end
            #1;
            budget--;
        end
        in_valid = 1'b0;
        n_checks++; if (q.size() != 0 || sent != 256) begin n_fail++; $display("FAIL wrap_timeout got sent=%0d left=%0d want sent=256 left=0", sent, q.size()); q.delete(); end
        n_checks++; if (saw_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_seen got %b want 1", saw_wrap); end
        n_checks++; if (word_cnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_final_cnt got %0d want %0d", word_cnt, exp_cnt); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle out_valid got %b want 0", out_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 8'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
